// File: rtl/elastic_chain_if.sv
// Handshake bundle for elastic_chain: upstream beat channel and downstream beat channel.
// The slave modport is the chain itself; the master modport is whatever surrounds it.
interface elastic_chain_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/elastic_chain.sv
// Elastic valid/ready register chain of DEPTH stages carrying CHANNELS lanes of WIDTH bits.
// Each lane either buffers or inverts at every stage; bubbles collapse and occupancy is registered.
module elastic_chain #(
  parameter int                   WIDTH    = 8,
  parameter int                   CHANNELS = 2,
  parameter int                   DEPTH    = 3,
  parameter logic [CHANNELS-1:0]  INV_MASK = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  elastic_chain_if.slave               link,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int DW = CHANNELS * WIDTH;
  localparam int OW = $clog2(DEPTH + 1);

  function automatic logic [DW-1:0] inv_word(input logic [CHANNELS-1:0] mask);
    logic [DW-1:0] w;
    w = '0;
    for (int c = 0; c < CHANNELS; c++) w[c*WIDTH +: WIDTH] = {WIDTH{mask[c]}};
    return w;
  endfunction

  localparam logic [DW-1:0] INV_WORD = inv_word(INV_MASK);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [DW-1:0]    d [DEPTH];
  logic             accept;
  logic             emit;

  // The ready chain walks back from the output: a stage can load if it is empty or
  // its own beat moves on, so a stall only reaches stages that are full.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    adv              = '0;
    load             = '0;
    adv[DEPTH-1]     = v[DEPTH-1] & link.out_ready;
    load[DEPTH-1]    = ~v[DEPTH-1] | adv[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i]  = v[i] & load[i+1];
      load[i] = ~v[i] | adv[i];
    end
  end

  assign link.in_ready  = load[0] & ~flush;
  assign link.out_valid = v[DEPTH-1] & ~flush;
  assign link.out_data  = d[DEPTH-1];

  assign accept = link.in_valid & link.in_ready;
  assign emit   = link.out_valid & link.out_ready;

  // NOTE: all state here uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      v         <= '0;
      occupancy <= '0;
      // NOTE: the data array is reset on purpose: out_data must read zero straight after rst.
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else if (flush) begin
      // Data registers are left untouched; only the valid bits and the count clear.
      v         <= '0;
      occupancy <= '0;
    end else begin
      if (load[0]) v[0] <= accept;
      for (int i = 1; i < DEPTH; i++) begin
        if (load[i]) v[i] <= v[i-1];
      end

      // Data moves only with a real beat, so empty stages never toggle.
      if (accept) d[0] <= link.in_data ^ INV_WORD;
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i-1]) d[i] <= d[i-1] ^ INV_WORD;
      end

      case ({accept, emit})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_elastic_chain.sv
// Bench for elastic_chain: directed scenarios plus random traffic scored against a FIFO model.
// A second instance with DEPTH=2 covers the even-depth data polarity and latency.
module tb_elastic_chain;

  localparam int             WIDTH    = 8;
  localparam int             CHANNELS = 2;
  localparam int             DEPTH    = 3;
  localparam logic [1:0]     INV_MASK = 2'b10;
  localparam int             DW       = WIDTH * CHANNELS;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [1:0] occ;
  logic [1:0] occ2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  elastic_chain_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus  ();
  elastic_chain_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus2 ();

  elastic_chain #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .INV_MASK(INV_MASK)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .link(bus.slave), .occupancy(occ)
  );

  elastic_chain #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(2), .INV_MASK(INV_MASK)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .link(bus2.slave), .occupancy(occ2)
  );

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_data   = bus.in_data;
  assign bus2.out_ready = bus.out_ready;

  always #5 clk = ~clk;

  // Net lane transform: an odd number of inverting stages inverts the lane.
  function automatic logic [DW-1:0] net_mask(input int depth);
    logic [DW-1:0] m;
    m = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (INV_MASK[c] && (depth % 2 == 1)) m[c*WIDTH +: WIDTH] = {WIDTH{1'b1}};
    return m;
  endfunction

  // Reference model: the chain is a FIFO of capacity DEPTH.
  logic [DW-1:0] q [$];
  logic [7:0]    elog [$];
  int            ecyc [$];

  logic          s_valid, s_ready, s2_valid;
  logic [DW-1:0] s_data, s2_data;
  logic [1:0]    s_occ;
  logic          last_acc, last_emt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: check against the model at the falling edge, update the model at the rising edge.
  task automatic step();
    logic acc, emt;
    logic exp_ready;
    @(negedge clk);
    cyc++;
    exp_ready = !flush && !(q.size() == DEPTH && !bus.out_ready);
    check("in_ready", bus.in_ready, exp_ready);
    check("occupancy", occ, q.size());
    if (flush) check("flush_out_valid", bus.out_valid, 1'b0);
    if (q.size() == 0) check("empty_out_valid", bus.out_valid, 1'b0);
    acc = bus.in_valid & bus.in_ready;
    emt = bus.out_valid & bus.out_ready;
    if (emt) begin
      if (q.size() == 0) check("spurious_emit", 1'b1, 1'b0);
      else               check("emit_data", bus.out_data, q[0]);
    end
    s_valid  = bus.out_valid;
    s_ready  = bus.in_ready;
    s_data   = bus.out_data;
    s_occ    = occ;
    s2_valid = bus2.out_valid;
    s2_data  = bus2.out_data;
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
    end else begin
      if (emt && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(bus.in_data ^ net_mask(DEPTH));
    end
    if (emt) begin
      elog.push_back(s_data[7:0]);
      ecyc.push_back(cyc);
    end
    last_acc = acc;
    last_emt = emt;
    #1;
  endtask

  task automatic single_beat(input logic [DW-1:0] din, input logic [DW-1:0] exp3,
                             input logic [DW-1:0] exp2);
    int t0, f3, f2;
    logic [DW-1:0] d3, d2;
    f3 = -1; f2 = -1; d3 = 'x; d2 = 'x;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = din;
    step();
    check("sb_accept", last_acc, 1'b1);
    t0 = cyc;
    bus.in_valid = 1'b0;
    repeat (6) begin
      step();
      if (s_valid && f3 < 0) begin f3 = cyc; d3 = s_data; end
      if (s2_valid && f2 < 0) begin f2 = cyc; d2 = s2_data; end
    end
    check("latency_d3", f3 - t0, 3);
    check("data_d3", d3, exp3);
    check("latency_d2", f2 - t0, 2);
    check("data_d2", d2, exp2);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (DEPTH + 2) step();
    check("drained", q.size(), 0);
  endtask

  initial begin
    int idx;
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    check("rst_out_valid", s_valid, 1'b0);
    check("rst_out_data", s_data, 16'h0000);
    check("rst_occ", s_occ, 0);
    check("rst_in_ready", s_ready, 1'b1);
    check("rst2_out_data", s2_data, 16'h0000);

    // Single beat, DEPTH=3 and DEPTH=2
    single_beat(16'h12A5, 16'hEDA5, 16'h12A5);

    // Backpressure
    bus.out_ready = 1'b0;
    idx = 1;
    repeat (4) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(idx);
      step();
      if (last_acc) idx++;
    end
    check("bp_accepted", idx - 1, 3);
    check("bp_occ", s_occ, 3);
    check("bp_in_ready", s_ready, 1'b0);
    elog.delete(); ecyc.delete();
    bus.out_ready = 1'b1;
    bus.in_data   = DW'(idx);
    repeat (6) begin
      step();
      if (last_acc) bus.in_valid = 1'b0;
    end
    check("bp_emit_count", elog.size(), 4);
    for (int i = 0; i < 4 && i < elog.size(); i++) begin
      check("bp_emit_value", elog[i], 8'(i + 1));
      if (i > 0) check("bp_emit_gap", ecyc[i] - ecyc[i-1], 1);
    end
    check("bp_occ_end", occ, 0);

    // Full pass-through
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (DEPTH) begin
      bus.in_data = DW'($urandom);
      step();
    end
    bus.out_ready = 1'b1;
    repeat (10) begin
      bus.in_data = DW'($urandom);
      step();
      check("pt_in_ready", s_ready, 1'b1);
      check("pt_occ", s_occ, 3);
      check("pt_emit", last_emt, 1'b1);
    end
    drain();

    // Bubble collapse
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = (c == 0 || c == 2);
      bus.in_data  = DW'(16'hA000 + c);
      step();
      check("bc_in_ready", s_ready, 1'b1);
    end
    check("bc_occ", s_occ, 2);
    check("bc_out_valid", s_valid, 1'b1);

    // Flush with two beats held
    elog.delete(); ecyc.delete();
    flush = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    step();
    check("fl_out_valid", s_valid, 1'b0);
    check("fl_in_ready", s_ready, 1'b0);
    check("fl_accept", last_acc, 1'b0);
    flush = 1'b0; bus.in_valid = 1'b0;
    step();
    check("fl_occ", s_occ, 0);
    repeat (4) step();
    check("fl_no_emit", elog.size(), 0);

    // Mid-stream reset
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    repeat (5) begin
      bus.in_data = DW'($urandom);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0; bus.in_valid = 1'b0;
    step();
    check("mr_out_valid", s_valid, 1'b0);
    check("mr_out_data", s_data, 16'h0000);
    check("mr_occ", s_occ, 0);
    check("mr_in_ready", s_ready, 1'b1);
    single_beat(16'h3C5A, 16'hC35A, 16'h3C5A);

    // Random traffic
    repeat (800) begin
      rst           = ($urandom_range(0, 99) == 0);
      flush         = ($urandom_range(0, 39) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.in_data   = DW'($urandom);
      step();
    end
    rst = 1'b0; flush = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
